// File: rtl/milano_pkg.sv
// milano_pkg: shared core types for register writeback.
// Revision 1.0
`default_nettype none

package milano_pkg;

   localparam int unsigned REG_NUM    = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] waddr;
      logic [XLEN-1:0]       wdata;
   } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_pend_buf.sv
// wb_pend_buf: one-entry holding buffer for an LSU writeback that lost the port to the ALU.
// Revision 1.0
`default_nettype none

module wb_pend_buf
   import milano_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alu_act_i,
   input  logic [REG_ADDR_W-1:0] alu_waddr_i,
   input  logic                  lsu_acc_i,
   input  wb_req_t               lsu_req_i,
   output wb_req_t               pend_o,
   output logic                  drain_o
);

   wb_req_t pend_d;
   wb_req_t pend_q;

   always_comb begin
      pend_d  = pend_q;
      drain_o = pend_q.we & ~alu_act_i;
      if (pend_q.we) begin
         // Leaves on drain, or is dropped when a younger ALU write hits the same rd.
         if (!alu_act_i || (alu_waddr_i == pend_q.waddr)) begin
            pend_d = '0;
         end
      end else if (lsu_acc_i && alu_act_i && (lsu_req_i.waddr != alu_waddr_i)
                   && (lsu_req_i.waddr != '0)) begin
         pend_d.we    = 1'b1;
         pend_d.waddr = lsu_req_i.waddr;
         pend_d.wdata = lsu_req_i.wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// wb_regfile: x0..x31 register file merging ALU and LSU writebacks, two bypassed read ports.
// Revision 1.0
`default_nettype none

module wb_regfile
   import milano_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter bit          BypassEn  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alu_rd_we_i,
   input  logic [REG_ADDR_W-1:0] alu_rd_waddr_i,
   input  logic [DataWidth-1:0]  alu_rd_wdata_i,
   input  logic                  lsu_rd_valid_i,
   output logic                  lsu_rd_ready_o,
   input  logic [REG_ADDR_W-1:0] lsu_rd_waddr_i,
   input  logic [DataWidth-1:0]  lsu_rd_wdata_i,
   input  logic [REG_ADDR_W-1:0] rs1_raddr_i,
   input  logic [REG_ADDR_W-1:0] rs2_raddr_i,
   output logic [DataWidth-1:0]  rs1_rdata_o,
   output logic [DataWidth-1:0]  rs2_rdata_o,
   output logic                  pend_valid_o,
   output logic [REG_ADDR_W-1:0] pend_waddr_o
);

   logic [DataWidth-1:0] regs_d [REG_NUM];
   logic [DataWidth-1:0] regs_q [REG_NUM];

   wb_req_t alu_req;
   wb_req_t lsu_req;
   wb_req_t pend;
   wb_req_t commit;
   logic    alu_act;
   logic    lsu_acc;
   logic    drain;

   assign alu_req.we    = alu_rd_we_i;
   assign alu_req.waddr = alu_rd_waddr_i;
   assign alu_req.wdata = alu_rd_wdata_i;
   assign lsu_req.we    = lsu_rd_valid_i;
   assign lsu_req.waddr = lsu_rd_waddr_i;
   assign lsu_req.wdata = lsu_rd_wdata_i;

   assign alu_act        = rst_ni & alu_req.we & (alu_req.waddr != '0);
   assign lsu_rd_ready_o = rst_ni & ~pend.we;
   assign lsu_acc        = lsu_req.we & lsu_rd_ready_o;

   wb_pend_buf u_pend_buf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .alu_act_i   (alu_act),
      .alu_waddr_i (alu_req.waddr),
      .lsu_acc_i   (lsu_acc),
      .lsu_req_i   (lsu_req),
      .pend_o      (pend),
      .drain_o     (drain)
   );

   assign pend_valid_o = pend.we;
   assign pend_waddr_o = pend.waddr;

   // Direct LSU commits and drains only happen without an active ALU write,
   // so a single array write port suffices.
   always_comb begin
      commit = '0;
      if (alu_act) begin
         commit = alu_req;
      end else if (drain) begin
         commit = pend;
      end else if (lsu_acc && (lsu_req.waddr != '0)) begin
         commit = lsu_req;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (commit.we) begin
         regs_d[commit.waddr] = commit.wdata;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [REG_ADDR_W-1:0] addr;
      logic [DataWidth-1:0]  data;

      assign addr = (p == 0) ? rs1_raddr_i : rs2_raddr_i;

      always_comb begin
         data = '0;
         if (rst_ni && (addr != '0)) begin
            data = regs_q[addr];
            if (BypassEn) begin
               if (pend.we && (pend.waddr == addr)) begin
                  data = pend.wdata;
               end
               if (commit.we && (commit.waddr == addr)) begin
                  data = commit.wdata;
               end
            end
         end
      end
   end

   assign rs1_rdata_o = g_rd[0].data;
   assign rs2_rdata_o = g_rd[1].data;

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Integer register file with writeback merge for the milano core. Accepts the ALU writeback (`alu_rd_we/waddr/wdata`) every cycle and a handshaked load writeback from the LSU. Resolves same-cycle port conflicts with a one-entry pending buffer, and serves two combinational read ports with write bypass to the decode stage.

## Interface
- `DataWidth`, 32: register width.
- `BypassEn`, 1: when 1, read ports forward in-flight write data; when 0, reads return array contents only.
- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `alu_rd_we_i` in 1: ALU write enable.
- `alu_rd_waddr_i` in 5: ALU destination register.
- `alu_rd_wdata_i` in DataWidth: ALU result.
- `lsu_rd_valid_i` in 1: load writeback valid.
- `lsu_rd_ready_o` out 1: load writeback ready.
- `lsu_rd_waddr_i` in 5: load destination register.
- `lsu_rd_wdata_i` in DataWidth: load data.
- `rs1_raddr_i`, `rs2_raddr_i` in 5: read addresses.
- `rs1_rdata_o`, `rs2_rdata_o` out DataWidth: read data, combinational.
- `pend_valid_o` out 1: pending buffer occupied.
- `pend_waddr_o` out 5: register held in the pending buffer, for hazard stall logic.

## Operation
- Array: x1..x31 flops; x0 reads 0 and all writes to x0 are dropped. LSU handshakes to x0 still complete.
- An ALU write is active when `alu_rd_we_i=1` and `alu_rd_waddr_i!=0`.
- ALU write has absolute priority and commits at the next edge.
- `lsu_rd_ready_o = rst_ni & !pend_valid_q`.
- An LSU beat is accepted on `valid & ready`.
- Accepted beat, no active ALU write: commits directly at the edge.
- Accepted beat, active ALU write, different rd: captured into the pending buffer, which sets `pend_valid`.
- Accepted beat, active ALU write, same rd: the ALU write is the younger one and wins. The LSU data is discarded and not buffered.
- Pending buffer drain: on any cycle with `pend_valid_q` and no active ALU write, the pending entry commits and `pend_valid` clears. No new LSU beat can arrive that cycle because ready=0.
- If `pend_valid_q` and an active ALU write targets the same rd, the pending entry is dropped (younger wins) and `pend_valid` clears.
- If `pend_valid_q` and an active ALU write targets a different rd, the pending entry holds.
- Read priority when `BypassEn=1`, for a nonzero address:
  1. active ALU write data;
  2. else the committing LSU beat or pending entry on its drain cycle;
  3. else a held pending entry;
  4. else the array.
- Address 0 always reads 0.
- No write is ever lost except by the younger-wins rules above.

## Timing
- Write-to-array latency is 1 edge. With bypass, a write is visible on read ports in the same cycle.
- Pending entry occupancy is at least 1 cycle and is unbounded while the ALU writes other registers every cycle.
- LSU ready drops the cycle after a capture and rises the cycle after drain or drop.
- Reset, asynchronous at any time including mid-drain:
  - all array entries become 0 and `pend_valid_q` becomes 0;
  - `pend_waddr_o=0`;
  - `lsu_rd_ready_o=0` while `rst_ni` is low, 1 after release;
  - read outputs become 0.
- An LSU beat presented during reset is not accepted.

## Structure
- `milano_pkg` gains:
  - `REG_NUM=32`;
  - `REG_ADDR_W=5`;
  - `wb_req_t` packed struct {we, waddr, wdata}, reused by the ALU, LSU and this block.
- One sub-module, `wb_pend_buf`, holds the one-entry pending buffer with its capture, drain and drop logic.
- The top level holds the array, the commit mux and the read bypass.

## Test plan
- Reset, then write x5=0x1234_5678 via the ALU → next cycle `rs1_raddr=5` reads 0x1234_5678. Writing x0=0xFFFF_FFFF → x0 reads 0.
- Same cycle: ALU x3=0xA, LSU x4=0xB → LSU accepted, `pend_valid_o=1`, `pend_waddr_o=4`, `ready=0`. Next cycle with no ALU write → x4 commits as 0xB and ready returns to 1.
- Same cycle: ALU x7=0x11, LSU x7=0x22 → handshake completes, x7=0x11, `pend_valid_o` stays 0.
- Pending x4=0xB, then ALU x4=0xC → pending dropped, x4=0xC, `pend_valid_o=0` next cycle.
- `BypassEn=1`: ALU writes x9=0x99 while `rs2_raddr=9` → `rs2_rdata=0x99` in the same cycle. Pending x4 held under ALU x3 writes → rs1=4 returns the pending data.
- Assert `rst_ni` low while pending x4=0xB → `pend_valid_o=0`, x4=0 and `lsu_rd_ready_o=0` immediately; ready=1 after release.
